stopwatch_ctrl: RTL and testbench

//  Front-panel controller that sequences the stopwatch/countdown datapath.
//  - Turns debounced key levels into single-cycle command pulses (start, stop, min_inc, hour_inc, clear).
//  - Arbitrates simultaneous key presses and locks out illegal commands per run state.
//  - Owns the countdown-mode register and the alarm beeper with acknowledge and timeout.
//  - Sits between the key debouncers and the datapath counter block, all in the 100 Hz domain.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/sw_key_repeat.sv | 67 ++++++
 rtl/stopwatch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, key priority indices and timing defaults for the
// stopwatch front-panel controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Key indices, lowest index wins arbitration.
  localparam int unsigned KEY_SS   = 0;
  localparam int unsigned KEY_CLR  = 1;
  localparam int unsigned KEY_HOUR = 2;
  localparam int unsigned KEY_MIN  = 3;
  localparam int unsigned NUM_KEYS = 4;

  localparam int unsigned RPT_DELAY_DEF   = 50;
  localparam int unsigned RPT_PERIOD_DEF  = 10;
  localparam int unsigned BEEP_CYCLES_DEF = 300;

endpackage

// File: rtl/sw_key_repeat.sv
// Rising-edge detector for one adjust key, with an optional hold-to-repeat
// generator enabled by STOPWATCH_AUTO_REPEAT_EN.
module sw_key_repeat
  import stopwatch_pkg::*;
`ifdef STOPWATCH_AUTO_REPEAT_EN
#(
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic key,
`ifdef STOPWATCH_AUTO_REPEAT_EN
  input  logic hold,
`endif
  output logic fire_c
);

  logic prev;
  logic rise;

  assign rise = key & ~prev;

  // History starts high so a key held through reset produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= key;
  end

`ifdef STOPWATCH_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] target;
  logic             rep_q;
  logic             tick;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign target  = rep_q ? CNT_W'(RPT_PERIOD) : CNT_W'(RPT_DELAY);
  assign tick    = key & prev & hold & (cnt_inc == target);

  // Counts cycles since the last pulse; any break in the hold restarts the delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else if (rise || !(key && hold)) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      rep_q <= 1'b1;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

  assign fire_c = rise | tick;
`else
  assign fire_c = rise;
`endif

endmodule

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: key edges to command pulses, run-state FSM, mode
// register and alarm beeper. Hold-to-repeat on adjust keys: STOPWATCH_AUTO_REPEAT_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
`ifdef STOPWATCH_AUTO_REPEAT_EN
  parameter int unsigned RPT_DELAY   = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD  = RPT_PERIOD_DEF,
`endif
  parameter int unsigned BEEP_CYCLES = BEEP_CYCLES_DEF
) (
  input  logic clk_100Hz,
  input  logic rst_n,
  input  logic key_ss,
  input  logic key_clr,
  input  logic key_min,
  input  logic key_hour,
  input  logic mode_sw,
  input  logic alarm,
  output logic start_p,
  output logic stop_p,
  output logic min_inc_p,
  output logic hour_inc_p,
  output logic clr_p,
  output logic countdown_mode,
  output logic run_led,
  output logic beep
);

  localparam int unsigned       BEEP_W    = $clog2(BEEP_CYCLES + 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

  state_t              state_q, state_d;
  logic                ss_prev, clr_prev, alarm_prev;
  logic                alarm_rise;
  logic                min_fire, hour_fire;
  logic [NUM_KEYS-1:0] key_edge;
  logic                adj_legal;
  logic                mode_apply;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic                start_d, stop_d, min_d, hour_d, clr_d, mode_d;

  assign key_edge[KEY_SS]   = key_ss & ~ss_prev;
  assign key_edge[KEY_CLR]  = key_clr & ~clr_prev;
  assign key_edge[KEY_HOUR] = hour_fire;
  assign key_edge[KEY_MIN]  = min_fire;
  assign alarm_rise         = alarm & ~alarm_prev;

  assign adj_legal  = ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) & countdown_mode;
  assign mode_apply = (state_q != ST_RUN) && (state_q != ST_ALARM) && (mode_sw != countdown_mode);

`ifdef STOPWATCH_AUTO_REPEAT_EN
  state_t state_d1;
  logic   state_stable, min_hold, hour_hold;

  // Repeat only while the key is held alone, adjust is legal and the state is settled.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) state_d1 <= ST_IDLE;
    else        state_d1 <= state_q;
  end

  assign state_stable = (state_q == state_d1);
  assign min_hold     = adj_legal & state_stable & ~(key_ss | key_clr | key_hour);
  assign hour_hold    = adj_legal & state_stable & ~(key_ss | key_clr | key_min);
`endif

  sw_key_repeat
`ifdef STOPWATCH_AUTO_REPEAT_EN
    #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD))
`endif
  u_min_key (
`ifdef STOPWATCH_AUTO_REPEAT_EN
    .hold   (min_hold),
`endif
    .clk    (clk_100Hz),
    .rst_n  (rst_n),
    .key    (key_min),
    .fire_c (min_fire)
  );

  sw_key_repeat
`ifdef STOPWATCH_AUTO_REPEAT_EN
    #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD))
`endif
  u_hour_key (
`ifdef STOPWATCH_AUTO_REPEAT_EN
    .hold   (hour_hold),
`endif
    .clk    (clk_100Hz),
    .rst_n  (rst_n),
    .key    (key_hour),
    .fire_c (hour_fire)
  );

  // Next state and next command; a pending mode change overrides every key.
  always_comb begin
    state_d    = state_q;
    beep_cnt_d = beep_cnt_q;
    mode_d     = countdown_mode;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    min_d      = 1'b0;
    hour_d     = 1'b0;
    clr_d      = 1'b0;

    if (mode_apply) begin
      mode_d  = mode_sw;
      clr_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (key_edge[KEY_SS]) begin
            start_d = 1'b1;
            state_d = ST_RUN;
          end else if (key_edge[KEY_CLR]) begin
            clr_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (key_edge[KEY_HOUR] && adj_legal) begin
            hour_d = 1'b1;
          end else if (key_edge[KEY_MIN] && adj_legal) begin
            min_d = 1'b1;
          end
        end
        ST_RUN: begin
          // The datapath stops itself at zero, so alarm entry issues no stop_p.
          if (alarm_rise && countdown_mode) begin
            state_d    = ST_ALARM;
            beep_cnt_d = '0;
          end else if (key_edge[KEY_SS]) begin
            stop_d  = 1'b1;
            state_d = ST_PAUSE;
          end
        end
        ST_ALARM: begin
          if ((|key_edge) || (beep_cnt_q == BEEP_LAST)) state_d = ST_IDLE;
          else                                          beep_cnt_d = beep_cnt_q + BEEP_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ss_prev        <= 1'b1;
      clr_prev       <= 1'b1;
      alarm_prev     <= 1'b1;
      beep_cnt_q     <= '0;
      countdown_mode <= 1'b0;
      start_p        <= 1'b0;
      stop_p         <= 1'b0;
      min_inc_p      <= 1'b0;
      hour_inc_p     <= 1'b0;
      clr_p          <= 1'b0;
      run_led        <= 1'b0;
      beep           <= 1'b0;
    end else begin
      state_q        <= state_d;
      ss_prev        <= key_ss;
      clr_prev       <= key_clr;
      alarm_prev     <= alarm;
      beep_cnt_q     <= beep_cnt_d;
      countdown_mode <= mode_d;
      start_p        <= start_d;
      stop_p         <= stop_d;
      min_inc_p      <= min_d;
      hour_inc_p     <= hour_d;
      clr_p          <= clr_d;
      run_led        <= (state_d == ST_RUN);
      beep           <= (state_d == ST_ALARM);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized run against a rule-level reference model.
module tb_stopwatch_ctrl;

  localparam int BEEP_N = 300;
  localparam int RPT_D  = 50;
  localparam int RPT_P  = 10;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_ALARM = 3;

  logic clk_100Hz = 1'b0;
  logic rst_n     = 1'b0;
  logic key_ss = 1'b0, key_clr = 1'b0, key_min = 1'b0, key_hour = 1'b0;
  logic mode_sw = 1'b0, alarm = 1'b0;
  logic start_p, stop_p, min_inc_p, hour_inc_p, clr_p, countdown_mode, run_led, beep;

  stopwatch_ctrl dut (
    .clk_100Hz      (clk_100Hz),
    .rst_n          (rst_n),
    .key_ss         (key_ss),
    .key_clr        (key_clr),
    .key_min        (key_min),
    .key_hour       (key_hour),
    .mode_sw        (mode_sw),
    .alarm          (alarm),
    .start_p        (start_p),
    .stop_p         (stop_p),
    .min_inc_p      (min_inc_p),
    .hour_inc_p     (hour_inc_p),
    .clr_p          (clr_p),
    .countdown_mode (countdown_mode),
    .run_led        (run_led),
    .beep           (beep)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int checks = 0;
  int errors = 0;

  // Output bundle order: start stop min hour clr mode run beep
  function automatic logic [7:0] outs();
    return {start_p, stop_p, min_inc_p, hour_inc_p, clr_p, countdown_mode, run_led, beep};
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (start stop min hour clr mode run beep)", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100Hz);
    #1;
  endtask

  // Input bundle order: ss clr min hour mode_sw alarm
  task automatic drive(input logic [5:0] v);
    {key_ss, key_clr, key_min, key_hour, mode_sw, alarm} = v;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk_100Hz);
    @(negedge clk_100Hz);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [5:0] in, input logic [7:0] exp, input string name);
    vec_t v;
    v.in   = in;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endfunction

  // Reference model: spec rules evaluated once per clock.
  int m_st, m_prev_st, m_beep_n;
  bit m_cd, p_ss, p_clr, p_mn, p_hr, p_al;
  int age[2];

  function automatic void model_reset();
    m_st = S_IDLE; m_prev_st = S_IDLE; m_beep_n = 0; m_cd = 1'b0;
    p_ss = 1'b1; p_clr = 1'b1; p_mn = 1'b1; p_hr = 1'b1; p_al = 1'b1;
    age[0] = 0; age[1] = 0;
  endfunction

  task automatic model_step(output logic [7:0] e);
    bit lvl[2], prv[2], req[2], ok[2];
    bit r_ss, r_clr, r_al, r_adj, rise_any, legal, solo_ok;
    bit o_start, o_stop, o_min, o_hour, o_clr;
    int nst;
    lvl[0] = key_min;  lvl[1] = key_hour;
    prv[0] = p_mn;     prv[1] = p_hr;
    r_ss  = key_ss && !p_ss;
    r_clr = key_clr && !p_clr;
    r_al  = alarm && !p_al;
    r_adj = (key_min && !p_mn) || (key_hour && !p_hr);
    rise_any = r_ss || r_clr || r_adj;
    legal   = (m_st == S_IDLE || m_st == S_PAUSE) && m_cd;
    solo_ok = legal && (m_st == m_prev_st);
    ok[0] = solo_ok && !(key_ss || key_clr || key_hour);
    ok[1] = solo_ok && !(key_ss || key_clr || key_min);
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      if (lvl[k] && !prv[k]) begin
        req[k] = 1'b1;
        age[k] = 0;
      end
`ifdef STOPWATCH_AUTO_REPEAT_EN
      else if (lvl[k] && ok[k]) begin
        age[k]++;
        req[k] = (age[k] == RPT_D) || (age[k] > RPT_D && ((age[k] - RPT_D) % RPT_P) == 0);
      end
`endif
      else begin
        age[k] = 0;
      end
    end

    nst = m_st;
    {o_start, o_stop, o_min, o_hour, o_clr} = 5'b0;
    if ((m_st == S_IDLE || m_st == S_PAUSE) && (mode_sw != m_cd)) begin
      m_cd  = mode_sw;
      o_clr = 1'b1;
      nst   = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE, S_PAUSE: begin
          if (r_ss)                begin o_start = 1'b1; nst = S_RUN; end
          else if (r_clr)          begin o_clr = 1'b1; nst = S_IDLE; end
          else if (legal && req[1]) o_hour = 1'b1;
          else if (legal && req[0]) o_min = 1'b1;
        end
        S_RUN: begin
          if (r_al && m_cd) begin nst = S_ALARM; m_beep_n = 1; end
          else if (r_ss)    begin o_stop = 1'b1; nst = S_PAUSE; end
        end
        default: begin
          if (rise_any || m_beep_n >= BEEP_N) nst = S_IDLE;
          else m_beep_n++;
        end
      endcase
    end
    p_ss = key_ss; p_clr = key_clr; p_mn = key_min; p_hr = key_hour; p_al = alarm;
    m_prev_st = m_st;
    m_st = nst;
    e = {o_start, o_stop, o_min, o_hour, o_clr, m_cd, nst == S_RUN, nst == S_ALARM};
  endtask

  initial begin
    int beep_len;
    int hits[$];
    int exp_hits[$];
    logic [7:0] e;

    // ss clr min hour msw alarm -> start stop min hour clr mode run beep
    add(6'b100000, 8'b00000000, "held_through_reset");
    add(6'b000000, 8'b00000000, "release");
    add(6'b100000, 8'b10000010, "press_start");
    add(6'b100000, 8'b00000010, "start_one_cycle");
    add(6'b000000, 8'b00000010, "run");
    add(6'b100000, 8'b01000000, "stop");
    add(6'b000000, 8'b00000000, "pause");
    add(6'b010000, 8'b00001000, "pause_clear");
    add(6'b000000, 8'b00000000, "idle");
    add(6'b110000, 8'b10000010, "ss_beats_clr");
    add(6'b000000, 8'b00000010, "run_after_start");
    add(6'b010000, 8'b00000010, "run_ignores_clr");
    add(6'b000000, 8'b00000010, "run_idle_keys");
    add(6'b000010, 8'b00000010, "mode_held_in_run");
    add(6'b100010, 8'b01000000, "stop_with_mode_pending");
    add(6'b000010, 8'b00001100, "mode_applied_clear");
    add(6'b000010, 8'b00000100, "countdown_idle");
    add(6'b000110, 8'b00010100, "idle_hour");
    add(6'b000110, 8'b00000100, "hour_single");
    add(6'b001010, 8'b00100100, "idle_min");
    add(6'b000010, 8'b00000100, "idle_release");
    add(6'b001110, 8'b00010100, "hour_beats_min");
    add(6'b000010, 8'b00000100, "idle_release2");
    add(6'b010110, 8'b00001100, "clr_beats_hour");
    add(6'b000010, 8'b00000100, "idle_release3");
    add(6'b100010, 8'b10000110, "start_countdown");
    add(6'b000010, 8'b00000110, "run_cd");
    add(6'b001010, 8'b00000110, "run_drops_min");
    add(6'b000110, 8'b00000110, "run_drops_hour");
    add(6'b000010, 8'b00000110, "run_cd2");
    add(6'b100010, 8'b01000100, "stop_to_pause");
    add(6'b000010, 8'b00000100, "pause_cd");
    add(6'b000110, 8'b00010100, "pause_hour");
    add(6'b001010, 8'b00100100, "pause_min");
    add(6'b000010, 8'b00000100, "pause_release");
    add(6'b100010, 8'b10000110, "restart");
    add(6'b000010, 8'b00000110, "run_cd3");
    add(6'b100011, 8'b00000101, "alarm_beats_ss");
    add(6'b000011, 8'b00000101, "beeping");
    add(6'b000111, 8'b00000100, "key_silences");
    add(6'b000011, 8'b00000100, "alarm_level_idle");
    add(6'b000010, 8'b00000100, "idle_cd");
    add(6'b100000, 8'b00001000, "mode_change_drops_ss");
    add(6'b000000, 8'b00000000, "idle_cd0");
    add(6'b001000, 8'b00000000, "min_dropped_cd0");
    add(6'b000000, 8'b00000000, "idle_end");

    // Reset with start/stop held through it
    drive(6'b100000);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_100Hz);
    #1;
    check8("reset_state", outs(), 8'b00000000);
    @(negedge clk_100Hz);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      check8(vecs[i].name, outs(), vecs[i].exp);
    end

    // Asynchronous reset truncates an in-flight pulse
    drive(6'b100000);
    tick();
    check8("pulse_before_reset", outs(), 8'b10000010);
    rst_n = 1'b0;
    #1;
    check8("reset_truncates", outs(), 8'b00000000);
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    drive(6'b000000);
    tick();
    check8("after_mid_reset", outs(), 8'b00000000);

    // Alarm timeout after BEEP_N cycles with no key
    drive(6'b000010);
    tick();
    check8("to_countdown", outs(), 8'b00001100);
    drive(6'b100010);
    tick();
    check8("cd_start", outs(), 8'b10000110);
    drive(6'b000010);
    tick();
    drive(6'b000011);
    tick();
    check8("alarm_entry", outs(), 8'b00000101);
    beep_len = 1;
    for (int n = 0; n < BEEP_N + 100; n++) begin
      tick();
      if (!beep) break;
      beep_len++;
    end
    check_int("beep_length", beep_len, BEEP_N);
    check8("after_timeout", outs(), 8'b00000100);
    drive(6'b000010);
    tick();

    // Holding the minute key in countdown IDLE
`ifdef STOPWATCH_AUTO_REPEAT_EN
    exp_hits = '{0, RPT_D, RPT_D + RPT_P, RPT_D + 2 * RPT_P, RPT_D + 3 * RPT_P};
`else
    exp_hits = '{0};
`endif
    drive(6'b001010);
    for (int n = 0; n <= RPT_D + 3 * RPT_P; n++) begin
      tick();
      if (min_inc_p) hits.push_back(n);
    end
    check_int("min_hold_pulses", hits.size(), exp_hits.size());
    for (int i = 0; i < exp_hits.size() && i < hits.size(); i++)
      check_int($sformatf("min_hold_at[%0d]", i), hits[i], exp_hits[i]);
    drive(6'b000010);
    tick();
    check8("min_released", outs(), 8'b00000100);

    // Randomized run against the reference model
    drive(6'b000000);
    do_reset(2);
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0)   key_ss   = ~key_ss;
      if ($urandom_range(0, 7) == 0)   key_clr  = ~key_clr;
      if ($urandom_range(0, 5) == 0)   key_min  = ~key_min;
      if ($urandom_range(0, 5) == 0)   key_hour = ~key_hour;
      if ($urandom_range(0, 99) == 0)  mode_sw  = ~mode_sw;
      if ($urandom_range(0, 29) == 0)  alarm    = ~alarm;
      model_step(e);
      tick();
      check8($sformatf("random[%0d]", n), outs(), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
